// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_pkg
//  Description : Opcode and FSM state encodings shared by the sequential ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

   // Opcodes presented on the op port
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   // Control FSM states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage : seq_alu_pkg
`default_nettype wire

// File: rtl/seq_alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_muldiv
//  Description : Iterative W-step datapath: shift-add multiply or restoring
//                divide, one bit per clock. The same hi/lo register pair holds
//                {product_hi, product_lo} or {remainder, quotient}.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_muldiv #(
   parameter int W = 8
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           start_i,
   input  logic           is_div_i,
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   output logic           done_o,
   output logic [2*W-1:0] res_o
);

   localparam int CW = $clog2(W) + 1;

   logic [CW-1:0] cnt_q;
   logic [W-1:0]  hi_q, lo_q, m_q;
   logic          is_div_q;

   logic [W:0]    mul_sum;
   logic [W:0]    div_shift;
   logic [W-1:0]  div_sub;
   logic          div_neg;
   logic [W-1:0]  hi_step, lo_step;

   // One iteration of the selected algorithm computed from the current registers
   always_comb begin
      mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? m_q : {W{1'b0}})};
      div_shift = {hi_q, lo_q[W-1]};
      div_neg   = (div_shift < {1'b0, m_q});
      // When the trial subtraction succeeds the difference is below the divisor,
      // so the low W bits of the shifted remainder minus divisor are exact.
      div_sub   = div_shift[W-1:0] - m_q;
      if (is_div_q) begin
         hi_step = div_neg ? div_shift[W-1:0] : div_sub;
         lo_step = {lo_q[W-2:0], ~div_neg};
      end else begin
         hi_step = mul_sum[W:1];
         lo_step = {mul_sum[0], lo_q[W-1:1]};
      end
   end

   // Load operands on start, then iterate while the counter is non-zero
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         m_q      <= '0;
         is_div_q <= 1'b0;
      end else if (start_i) begin
         cnt_q    <= CW'(W);
         hi_q     <= '0;
         lo_q     <= is_div_i ? a_i : b_i;
         m_q      <= is_div_i ? b_i : a_i;
         is_div_q <= is_div_i;
      end else if (cnt_q != '0) begin
         cnt_q    <= cnt_q - CW'(1);
         hi_q     <= hi_step;
         lo_q     <= lo_step;
      end
   end

   // done marks the edge performing the final iteration; res_o is its outcome
   assign done_o = (cnt_q == CW'(1));
   assign res_o  = {hi_step, lo_step};

endmodule : seq_alu_muldiv
`default_nettype wire

// File: rtl/seq_alu_w.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_w
//  Description : Handshaked W-bit ALU. ADD/SUB and divide-by-zero complete in
//                the accept edge; MUL/DIV iterate W further edges. Result and
//                flags are registered and held until out_valid & out_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_w
   import seq_alu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic           CLK,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [1:0]     op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] result,
   output logic           flag_zero,
   output logic           flag_carry,
   output logic           flag_dbz
);

   logic [1:0]     state_q, state_d;
   logic [2*W-1:0] result_q, result_d;
   logic           zero_q, zero_d;
   logic           carry_q, carry_d;
   logic           dbz_q, dbz_d;

   logic           accept;
   logic           is_dbz;
   logic           md_start;
   logic           md_done;
   logic [2*W-1:0] md_res;
   logic [W:0]     add_sum;
   logic [W:0]     sub_diff;
   logic           load;

   assign accept   = in_valid & in_ready;
   assign is_dbz   = (op == OP_DIV) && (b == '0);
   assign md_start = accept & op[1] & ~is_dbz;
   assign add_sum  = {1'b0, a} + {1'b0, b};
   assign sub_diff = {1'b0, a} - {1'b0, b};

   seq_alu_muldiv #(.W(W)) u_muldiv (
      .clk_i    (CLK),
      .rst_ni   (rst_n),
      .start_i  (md_start),
      .is_div_i (op == OP_DIV),
      .a_i      (a),
      .b_i      (b),
      .done_o   (md_done),
      .res_o    (md_res)
   );

   // State register
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: single-cycle ops go straight to DONE, MUL/DIV via BUSY
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = md_start ? ST_BUSY : ST_DONE;
         ST_BUSY: if (md_done) state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from the state
   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   // Result/flag selection: capture on accept or on the final iteration, else hold
   always_comb begin
      result_d = result_q;
      carry_d  = carry_q;
      dbz_d    = dbz_q;
      load     = 1'b0;
      if (accept && !md_start) begin
         load    = 1'b1;
         carry_d = 1'b0;
         dbz_d   = 1'b0;
         case (op)
            OP_ADD: begin
               result_d = {{(W-1){1'b0}}, add_sum};
               carry_d  = add_sum[W];
            end
            OP_SUB: begin
               result_d = {{W{1'b0}}, sub_diff[W-1:0]};
               carry_d  = sub_diff[W];
            end
            default: begin
               // Only divide-by-zero reaches here without iterating
               result_d = {a, {W{1'b1}}};
               dbz_d    = 1'b1;
            end
         endcase
      end else if ((state_q == ST_BUSY) && md_done) begin
         load     = 1'b1;
         result_d = md_res;
         carry_d  = 1'b0;
         dbz_d    = 1'b0;
      end
      zero_d = load ? (result_d == '0) : zero_q;
   end

   // Result and flag registers
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         dbz_q    <= dbz_d;
      end
   end

   assign result     = result_q;
   assign flag_zero  = zero_q;
   assign flag_carry = carry_q;
   assign flag_dbz   = dbz_q;

endmodule : seq_alu_w
`default_nettype wire

// File: tb/tb_seq_alu_w.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu_w
//  Description : Self-checking bench for seq_alu_w with a transaction-level
//                reference model, directed literal cases and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu_w;

   localparam int W  = 8;
   localparam int W2 = 2 * W;

   logic          CLK = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    op = 2'b00;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W2-1:0] result;
   logic          flag_zero, flag_carry, flag_dbz;

   int errors = 0;
   int checks = 0;

   seq_alu_w #(.W(W)) dut (
      .CLK        (CLK),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .a          (a),
      .b          (b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .flag_zero  (flag_zero),
      .flag_carry (flag_carry),
      .flag_dbz   (flag_dbz)
   );

   always #5 CLK = ~CLK;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Arithmetic reference: expected result, flags and extra edges after accept
   function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W2-1:0] r, output logic c, output logic d,
                                  output int lat);
      int ai, bi, mask;
      ai = int'(x); bi = int'(y); mask = (1 << W) - 1;
      c = 1'b0; d = 1'b0; lat = 0; r = '0;
      case (o)
         2'd0: begin r = W2'(ai + bi); c = (ai + bi) > mask; end
         2'd1: begin r = W2'((ai - bi) & mask); c = ai < bi; end
         2'd2: begin r = W2'(ai * bi); lat = W; end
         default: begin
            if (bi == 0) begin r = W2'((ai << W) | mask); d = 1'b1; end
            else begin r = W2'(((ai % bi) << W) | (ai / bi)); lat = W; end
         end
      endcase
   endfunction

   // Reference model: 0 = accepting, 1 = computing, 2 = presenting result
   int            m_mode = 0;
   int            m_left = 0;
   logic [W2-1:0] m_res = '0;
   logic          m_c = 1'b0, m_d = 1'b0;

   always @(posedge CLK or negedge rst_n) begin
      int lat;
      if (!rst_n) begin
         m_mode = 0; m_left = 0; m_res = '0; m_c = 1'b0; m_d = 1'b0;
      end else begin
         case (m_mode)
            0: if (in_valid) begin
                  ref_op(op, a, b, m_res, m_c, m_d, lat);
                  if (lat == 0) m_mode = 2;
                  else begin m_mode = 1; m_left = lat; end
               end
            1: begin
                  m_left--;
                  if (m_left == 0) m_mode = 2;
               end
            default: if (out_ready) m_mode = 0;
         endcase
      end
   end

   // Cycle-by-cycle comparison of the DUT against the model
   always @(negedge CLK) begin
      if (rst_n) begin
         chk("in_ready", 64'(in_ready), 64'(m_mode == 0));
         chk("out_valid", 64'(out_valid), 64'(m_mode == 2));
         if (m_mode == 2) begin
            chk("result", 64'(result), 64'(m_res));
            chk("flag_zero", 64'(flag_zero), 64'(m_res == '0));
            chk("flag_carry", 64'(flag_carry), 64'(m_c));
            chk("flag_dbz", 64'(flag_dbz), 64'(m_d));
         end
      end
   end

   // Wait, with a bound, for out_valid; called at posedge+1 after the accept edge
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge CLK); #1;
         lat++;
      end
   endtask

   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W2-1:0] er, input logic ec, input logic ez,
                         input logic ed, input int elat, input string nm);
      int lat;
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      a = ~x; b = ~y;
      wait_valid(lat);
      chk({nm, " latency"}, 64'(lat), 64'(elat));
      chk({nm, " result"}, 64'(result), 64'(er));
      chk({nm, " carry"}, 64'(flag_carry), 64'(ec));
      chk({nm, " zero"}, 64'(flag_zero), 64'(ez));
      chk({nm, " dbz"}, 64'(flag_dbz), 64'(ed));
      @(posedge CLK); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset in_ready", 64'(in_ready), 64'd1);
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset result", 64'(result), 64'd0);
      chk("reset flags", 64'({flag_zero, flag_carry, flag_dbz}), 64'd0);
      #2 rst_n = 1'b1;
      @(posedge CLK); #1;

      // Directed cases with hand-computed expectations
      run_op(2'b00, 8'd200, 8'd100, 16'h012C, 1'b1, 1'b0, 1'b0, 0, "ADD 200+100");
      run_op(2'b01, 8'd5,   8'd7,   16'h00FE, 1'b1, 1'b0, 1'b0, 0, "SUB 5-7");
      run_op(2'b01, 8'd7,   8'd7,   16'h0000, 1'b0, 1'b1, 1'b0, 0, "SUB 7-7");
      run_op(2'b10, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 1'b0, W, "MUL 255*255");
      run_op(2'b11, 8'd100, 8'd7,   16'h020E, 1'b0, 1'b0, 1'b0, W, "DIV 100/7");
      run_op(2'b11, 8'd9,   8'd0,   16'h09FF, 1'b0, 1'b0, 1'b1, 0, "DIV 9/0");
      run_op(2'b10, 8'd0,   8'd77,  16'h0000, 1'b0, 1'b1, 1'b0, W, "MUL 0*77");
      run_op(2'b11, 8'd3,   8'd200, 16'h0300, 1'b0, 1'b0, 1'b0, W, "DIV 3/200");

      // Backpressure: result held, requests ignored, release frees the block
      out_ready = 1'b0;
      op = 2'b10; a = 8'd255; b = 8'd255; in_valid = 1'b1;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      wait_valid(lat);
      chk("bp latency", 64'(lat), 64'(W));
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; op = 2'b00; a = 8'd1; b = 8'd1;
         @(posedge CLK); #1;
         chk("bp held result", 64'(result), 64'h0000_0000_0000_FE01);
         chk("bp held in_ready", 64'(in_ready), 64'd0);
         chk("bp held out_valid", 64'(out_valid), 64'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge CLK); #1;
      chk("bp release in_ready", 64'(in_ready), 64'd1);
      chk("bp release out_valid", 64'(out_valid), 64'd0);
      @(posedge CLK); #1;
      chk("bp nothing queued", 64'(out_valid), 64'd0);

      // Asynchronous reset in the middle of a multiply
      op = 2'b10; a = 8'd123; b = 8'd45; in_valid = 1'b1;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge CLK);
      #2 rst_n = 1'b0;
      #1;
      chk("abort out_valid", 64'(out_valid), 64'd0);
      chk("abort result", 64'(result), 64'd0);
      chk("abort in_ready", 64'(in_ready), 64'd1);
      #1 rst_n = 1'b1;
      @(posedge CLK); #1;
      run_op(2'b00, 8'd1, 8'd1, 16'h0002, 1'b0, 1'b0, 1'b0, 0, "ADD after abort");

      // Random traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         op        = 2'($urandom_range(0, 3));
         a         = W'($urandom);
         b         = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge CLK); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (W + 4) @(posedge CLK);
      #1;
      chk("drain in_ready", 64'(in_ready), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_seq_alu_w
`default_nettype wire
